// File: rtl/code_entry_pkg.sv
// ============================================================================
// Module      : code_entry_pkg
// Description : Shared key codes, debounce state encoding and a popcount
//               helper for the code_entry block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package code_entry_pkg;

  localparam logic [3:0] KEY_CLEAR     = 4'hE;
  localparam logic [3:0] KEY_SUBMIT    = 4'hF;
  localparam logic [3:0] KEY_DIGIT_MAX = 4'd9;

  localparam int         DB_STATE_W  = 2;
  localparam logic [1:0] ST_WAIT_REL = 2'd0;
  localparam logic [1:0] ST_ARMED    = 2'd1;
  localparam logic [1:0] ST_SETTLE   = 2'd2;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/key_debounce.sv
// ============================================================================
// Module      : key_debounce
// Description : Row synchronizer plus press/settle/release FSM; emits one
//               key_strobe with the captured key_value per physical press.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_debounce
  import code_entry_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 500000,
  parameter int RELEASE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_code,
  input  logic [3:0] row_in,
  output logic       key_strobe,
  output logic [3:0] key_value
);

  localparam int c_TMR_MAX = (SETTLE_CYCLES > RELEASE_CYCLES) ? SETTLE_CYCLES : RELEASE_CYCLES;
  localparam int c_TMR_W   = $clog2(c_TMR_MAX + 1);
  localparam logic [c_TMR_W-1:0] c_SETTLE_LAST  = c_TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [c_TMR_W-1:0] c_RELEASE_LAST = c_TMR_W'(RELEASE_CYCLES - 1);

  logic [3:0]            r_sync1;
  logic [3:0]            r_sync2;
  logic                  w_row_any;
  logic [DB_STATE_W-1:0] r_state;
  logic [DB_STATE_W-1:0] w_state_next;
  logic [c_TMR_W-1:0]    r_timer;
  logic                  w_capture;
  logic                  r_key_strobe;
  logic [3:0]            r_key_value;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 4'b1111;
      r_sync2 <= 4'b1111;
    end else begin
      r_sync1 <= row_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_row_any = ~&r_sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_WAIT_REL;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_WAIT_REL: if (!w_row_any && (r_timer == c_RELEASE_LAST)) w_state_next = ST_ARMED;
      ST_ARMED:    if (w_row_any) w_state_next = ST_SETTLE;
      ST_SETTLE:   if (r_timer == c_SETTLE_LAST) w_state_next = ST_WAIT_REL;
      default:     w_state_next = ST_WAIT_REL;
    endcase
  end

  always_comb begin
    w_capture = (r_state == ST_SETTLE) && (r_timer == c_SETTLE_LAST);
  end

  // Shared up-counter: release run length in WAIT_REL, settle time in SETTLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_timer <= '0;
    end else begin
      case (r_state)
        ST_WAIT_REL: begin
          if (w_row_any || (r_timer == c_RELEASE_LAST)) r_timer <= '0;
          else                                          r_timer <= r_timer + 1'b1;
        end
        ST_SETTLE: begin
          if (w_capture) r_timer <= '0;
          else           r_timer <= r_timer + 1'b1;
        end
        default: r_timer <= '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_key_strobe <= 1'b0;
      r_key_value  <= 4'd0;
    end else begin
      r_key_strobe <= w_capture;
      if (w_capture) r_key_value <= key_code;
    end
  end

  assign key_strobe = r_key_strobe;
  assign key_value  = r_key_value;

endmodule

`default_nettype wire

// File: rtl/code_entry.sv
// ============================================================================
// Module      : code_entry
// Description : Debounced keypad entry buffer with secret-code comparator.
//               Macro CODE_ENTRY_PARTIAL_EN enables the per-digit exact count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module code_entry
  import code_entry_pkg::*;
#(
  parameter int                  CODE_LEN       = 4,
  parameter logic [4*CODE_LEN-1:0] SECRET       = 16'h1234,
  parameter int                  SETTLE_CYCLES  = 500000,
  parameter int                  RELEASE_CYCLES = 500000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            key_code,
  input  logic [3:0]            row_in,
  output logic                  key_strobe,
  output logic [3:0]            key_value,
  output logic [4*CODE_LEN-1:0] entry,
  output logic [3:0]            entry_count,
  output logic                  result_valid,
  output logic                  result_match,
  output logic [3:0]            result_exact
);

  localparam int         c_ENTRY_W = 4 * CODE_LEN;
  localparam logic [3:0] c_LEN     = 4'(CODE_LEN);

  logic                 w_key_strobe;
  logic [3:0]           w_key_value;
  logic [c_ENTRY_W-1:0] w_digit_ext;
  logic                 w_match;
  logic [3:0]           w_exact;
  logic [c_ENTRY_W-1:0] r_entry;
  logic [3:0]           r_count;
  logic                 r_result_valid;
  logic                 r_result_match;
  logic [3:0]           r_result_exact;

  key_debounce #(
    .SETTLE_CYCLES  (SETTLE_CYCLES),
    .RELEASE_CYCLES (RELEASE_CYCLES)
  ) u_debounce (
    .clk        (clk),
    .rst        (rst),
    .key_code   (key_code),
    .row_in     (row_in),
    .key_strobe (w_key_strobe),
    .key_value  (w_key_value)
  );

  assign w_digit_ext = c_ENTRY_W'(w_key_value);
  assign w_match     = (r_entry == SECRET);

`ifdef CODE_ENTRY_PARTIAL_EN
  logic [7:0] w_digit_eq;

  for (genvar gi = 0; gi < 8; gi++) begin : g_digit_eq
    if (gi < CODE_LEN) begin : g_used
      assign w_digit_eq[gi] = (r_entry[4*gi +: 4] == SECRET[4*gi +: 4]);
    end else begin : g_unused
      assign w_digit_eq[gi] = 1'b0;
    end
  end

  assign w_exact = popcount8(w_digit_eq);
`else
  assign w_exact = 4'd0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_entry        <= '0;
      r_count        <= 4'd0;
      r_result_valid <= 1'b0;
      r_result_match <= 1'b0;
      r_result_exact <= 4'd0;
    end else begin
      r_result_valid <= 1'b0;
      if (w_key_strobe) begin
        if (w_key_value <= KEY_DIGIT_MAX) begin
          if (r_count < c_LEN) begin
            r_entry <= (r_entry << 4) | w_digit_ext;
            r_count <= r_count + 4'd1;
          end
        end else if (w_key_value == KEY_CLEAR) begin
          r_entry <= '0;
          r_count <= 4'd0;
        end else if ((w_key_value == KEY_SUBMIT) && (r_count == c_LEN)) begin
          r_result_valid <= 1'b1;
          r_result_match <= w_match;
          r_result_exact <= w_exact;
          r_entry        <= '0;
          r_count        <= 4'd0;
        end
      end
    end
  end

  assign key_strobe   = w_key_strobe;
  assign key_value    = w_key_value;
  assign entry        = r_entry;
  assign entry_count  = r_count;
  assign result_valid = r_result_valid;
  assign result_match = r_result_match;
  assign result_exact = r_result_exact;

endmodule

`default_nettype wire

// File: tb/tb_code_entry.sv
// ============================================================================
// Module      : tb_code_entry
// Description : Self-checking bench for code_entry with short debounce timers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_code_entry;

  localparam int SETTLE  = 8;
  localparam int RELEASE = 16;
  localparam int LATENCY = 3 + SETTLE;  // 2 sync flops + ARMED sample + settle

`ifdef CODE_ENTRY_PARTIAL_EN
  localparam logic [3:0] EX4 = 4'd4;
  localparam logic [3:0] EX2 = 4'd2;
`else
  localparam logic [3:0] EX4 = 4'd0;
  localparam logic [3:0] EX2 = 4'd0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  key_code;
  logic [3:0]  row_in;
  logic        key_strobe;
  logic [3:0]  key_value;
  logic [15:0] entry;
  logic [3:0]  entry_count;
  logic        result_valid;
  logic        result_match;
  logic [3:0]  result_exact;

  typedef struct {
    logic [3:0]  key;
    logic [3:0]  cnt;
    logic [15:0] ent;
    bit          res;
    bit          match;
    logic [3:0]  exact;
  } rec_t;

  typedef struct {
    bit         match;
    logic [3:0] exact;
  } res_t;

  logic [3:0] key_q[$];
  res_t       res_q[$];
  rec_t       tbl[$];
  int total = 0;
  int bad   = 0;
  int strobe_cnt = 0;
  bit last_match = 1'b0;
  logic [3:0] last_exact = 4'd0;

  code_entry #(
    .CODE_LEN       (4),
    .SECRET         (16'h1234),
    .SETTLE_CYCLES  (SETTLE),
    .RELEASE_CYCLES (RELEASE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .key_code     (key_code),
    .row_in       (row_in),
    .key_strobe   (key_strobe),
    .key_value    (key_value),
    .entry        (entry),
    .entry_count  (entry_count),
    .result_valid (result_valid),
    .result_match (result_match),
    .result_exact (result_exact)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard consumers: every strobe/result must match a queued expectation.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (key_strobe) begin
        strobe_cnt++;
        if (key_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_strobe actual=%0h required=none", key_value);
        end else begin
          check("key_value", {28'd0, key_value}, {28'd0, key_q.pop_front()});
        end
      end
      if (result_valid) begin
        if (res_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_result actual=%0b required=none", result_match);
        end else begin
          res_t r;
          r = res_q.pop_front();
          check("result_match", {31'd0, result_match}, {31'd0, r.match});
          check("result_exact", {28'd0, result_exact}, {28'd0, r.exact});
        end
      end
    end
  end

  task automatic wait_strobe(output int lat);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (key_strobe) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic release_rows(input int n);
    row_in = 4'b1111;
    repeat (n) @(negedge clk);
  endtask

  // Press with scan-like row toggling while held, then a full release.
  task automatic press(input logic [3:0] k, input int hold);
    int lat;
    key_q.push_back(k);
    key_code = k;
    row_in   = 4'b0111;
    wait_strobe(lat);
    check("strobe_latency", lat, LATENCY);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      row_in = (i % 4 == 0) ? 4'b1011 : 4'b1111;
    end
    release_rows(RELEASE + 4);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int s0;

    rst = 1'b1; key_code = 4'd0; row_in = 4'b1111;
    repeat (3) @(negedge clk);
    check("rst_strobe", {31'd0, key_strobe}, 0);
    check("rst_value", {28'd0, key_value}, 0);
    check("rst_entry", {16'd0, entry}, 0);
    check("rst_count", {28'd0, entry_count}, 0);
    check("rst_rv", {31'd0, result_valid}, 0);
    check("rst_match", {31'd0, result_match}, 0);
    check("rst_exact", {28'd0, result_exact}, 0);
    rst = 1'b0;
    repeat (RELEASE) @(negedge clk);

    // First press: latency and one-cycle-later entry update.
    key_q.push_back(4'd1);
    key_code = 4'd1;
    row_in   = 4'b0111;
    wait_strobe(lat);
    check("first_latency", lat, LATENCY);
    check("count_at_strobe", {28'd0, entry_count}, 0);
    @(negedge clk);
    check("count_after_strobe", {28'd0, entry_count}, 1);
    check("entry_after_strobe", {16'd0, entry}, 16'h0001);
    release_rows(RELEASE + 4);

    // Long scanned hold yields exactly one strobe.
    s0 = strobe_cnt;
    press(4'd2, 1000);
    check("held_strobes", strobe_cnt - s0, 1);
    check("held_entry", {16'd0, entry}, 16'h0012);

    tbl.push_back('{4'hE, 4'd0, 16'h0000, 1'b0, 1'b0, 4'd0});
    tbl.push_back('{4'h1, 4'd1, 16'h0001, 1'b0, 1'b0, 4'd0});
    tbl.push_back('{4'h2, 4'd2, 16'h0012, 1'b0, 1'b0, 4'd0});
    tbl.push_back('{4'h3, 4'd3, 16'h0123, 1'b0, 1'b0, 4'd0});
    tbl.push_back('{4'h4, 4'd4, 16'h1234, 1'b0, 1'b0, 4'd0});
    tbl.push_back('{4'hF, 4'd0, 16'h0000, 1'b1, 1'b1, EX4});
    tbl.push_back('{4'h1, 4'd1, 16'h0001, 1'b0, 1'b0, 4'd0});
    tbl.push_back('{4'h2, 4'd2, 16'h0012, 1'b0, 1'b0, 4'd0});
    tbl.push_back('{4'h4, 4'd3, 16'h0124, 1'b0, 1'b0, 4'd0});
    tbl.push_back('{4'h3, 4'd4, 16'h1243, 1'b0, 1'b0, 4'd0});
    tbl.push_back('{4'hF, 4'd0, 16'h0000, 1'b1, 1'b0, EX2});
    tbl.push_back('{4'h5, 4'd1, 16'h0005, 1'b0, 1'b0, 4'd0});
    tbl.push_back('{4'h6, 4'd2, 16'h0056, 1'b0, 1'b0, 4'd0});
    tbl.push_back('{4'h7, 4'd3, 16'h0567, 1'b0, 1'b0, 4'd0});
    tbl.push_back('{4'h8, 4'd4, 16'h5678, 1'b0, 1'b0, 4'd0});
    tbl.push_back('{4'h9, 4'd4, 16'h5678, 1'b0, 1'b0, 4'd0});
    tbl.push_back('{4'hA, 4'd4, 16'h5678, 1'b0, 1'b0, 4'd0});
    tbl.push_back('{4'hF, 4'd0, 16'h0000, 1'b1, 1'b0, 4'd0});
    tbl.push_back('{4'h1, 4'd1, 16'h0001, 1'b0, 1'b0, 4'd0});
    tbl.push_back('{4'h2, 4'd2, 16'h0012, 1'b0, 1'b0, 4'd0});
    tbl.push_back('{4'h3, 4'd3, 16'h0123, 1'b0, 1'b0, 4'd0});
    tbl.push_back('{4'hF, 4'd3, 16'h0123, 1'b0, 1'b0, 4'd0});
    tbl.push_back('{4'hE, 4'd0, 16'h0000, 1'b0, 1'b0, 4'd0});

    foreach (tbl[i]) begin
      if (tbl[i].res) begin
        res_q.push_back('{tbl[i].match, tbl[i].exact});
        last_match = tbl[i].match;
        last_exact = tbl[i].exact;
      end
      press(tbl[i].key, 6);
      check($sformatf("tbl%0d_count", i), {28'd0, entry_count}, {28'd0, tbl[i].cnt});
      check($sformatf("tbl%0d_entry", i), {16'd0, entry}, {16'd0, tbl[i].ent});
      check($sformatf("tbl%0d_match_hold", i), {31'd0, result_match}, {31'd0, last_match});
      check($sformatf("tbl%0d_exact_hold", i), {28'd0, result_exact}, {28'd0, last_exact});
    end

    // Reset mid-settle discards the key and the entry.
    press(4'd5, 2);
    check("pre_rst_count", {28'd0, entry_count}, 1);
    s0 = strobe_cnt;
    key_code = 4'd7;
    row_in   = 4'b0111;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_settle_entry", {16'd0, entry}, 0);
    check("rst_settle_count", {28'd0, entry_count}, 0);
    repeat (30) @(negedge clk);
    release_rows(RELEASE - 6);
    row_in = 4'b0111;
    repeat (30) @(negedge clk);
    check("rst_no_strobe", strobe_cnt - s0, 0);
    release_rows(RELEASE + 4);
    press(4'd7, 2);
    check("rst_next_strobes", strobe_cnt - s0, 1);
    check("rst_next_entry", {16'd0, entry}, 16'h0007);

    check("key_q_empty", key_q.size(), 0);
    check("res_q_empty", res_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/code_entry.md
# code_entry

Consumes the keypad decoder's 4-bit key code and the raw keypad row lines. Turns each physical key press into exactly one accepted key event, and assembles digit presses into a CODE_LEN-digit guess. On submit, it compares the guess against a secret code and reports the result to the game logic. It sits directly downstream of the keypad column-scan decoder.

## Interface
- CODE_LEN, 4: digits per guess (1..8).
- SECRET, 16'h1234: secret code, 4 bits per digit; most-significant nibble is the first digit.
- SETTLE_CYCLES, 500000: clocks from press detection to key capture (5 ms, more than one full 4-column scan).
- RELEASE_CYCLES, 500000: consecutive all-high row clocks that declare a release.
- clk  in  1  100 MHz system clock.
- rst  in  1  synchronous, active-high reset.
- key_code  in  4  decoder key value, held between presses.
- row_in  in  4  raw keypad rows, active low, asynchronous.
- key_strobe  out  1  one-cycle pulse when a key is accepted.
- key_value  out  4  key accepted with the last strobe.
- entry  out  4*CODE_LEN  digits entered so far; newest digit in the low nibble.
- entry_count  out  4  number of digits held (0..CODE_LEN).
- result_valid  out  1  one-cycle pulse after a valid submit.
- result_match  out  1  guess equals SECRET; valid with result_valid.
- result_exact  out  4  count of digits correct in position; valid with result_valid.

## Operation
- row_in passes through a 2-FF synchronizer, reset to 4'b1111. row_any = any synchronized bit low.
- Debounce FSM:
  - WAIT_REL (reset state): counts consecutive !row_any clocks; any row_any clears the count. Reaching RELEASE_CYCLES goes to ARMED.
  - ARMED: row_any goes to SETTLE and loads the timer.
  - SETTLE: counts SETTLE_CYCLES regardless of row activity (scanning makes the rows toggle). At expiry it captures key_code into key_value, pulses key_strobe, and goes to WAIT_REL.
- One accept per press. A held key, repeated presses inside the release window, or bounce never produce a second strobe.
- Key handling on key_strobe (takes effect the next cycle):
  - 0–9: if entry_count < CODE_LEN, shift entry left 4 and insert the digit; otherwise ignore.
  - 4'hE, clear: entry = 0, entry_count = 0.
  - 4'hF, submit: if entry_count == CODE_LEN, compute the result, pulse result_valid, and clear entry and count. Otherwise ignore.
  - 4'hA–4'hD: ignored.
- Comparison: result_match = (entry == SECRET). result_exact = popcount of per-nibble equality, width 4, at most CODE_LEN.

## Timing
- Reset values: all outputs 0, FSM in WAIT_REL, timers 0, synchronizer 4'b1111.
- After reset, a key already held is not accepted until it has been released for RELEASE_CYCLES.
- Press latency: the first raw low edge reaches row_any after 2 clocks. key_strobe fires SETTLE_CYCLES clocks after row_any is first seen in ARMED.
- entry and entry_count update 1 clock after key_strobe.
- result_valid, result_match and result_exact appear 1 clock after the submit key_strobe. result_match and result_exact hold until the next result_valid.
- rst mid-SETTLE: the key is discarded with no strobe, and entry is cleared.
- If a key_strobe coincides with rst, rst wins.

## Configuration
- CODE_ENTRY_PARTIAL_EN defined: result_exact is computed as specified.
- CODE_ENTRY_PARTIAL_EN undefined: result_exact is tied to 0, the per-digit comparators are removed, and result_match is unchanged.

## Structure
- Package code_entry_pkg holds:
  - KEY_CLEAR = 4'hE and KEY_SUBMIT = 4'hF.
  - the debounce state encoding (WAIT_REL, ARMED, SETTLE).
  - the digit-range constant 4'd9.
- Sub-module key_debounce holds the synchronizer, the FSM and both timers. Its outputs are key_strobe and key_value.
- The parent holds the entry buffer and the comparator.

## Test plan
All scenarios use SETTLE_CYCLES=8, RELEASE_CYCLES=16, SECRET=16'h1234.
- Reset release with rows all high for 16 clocks, then row_in=4'b0111 and key_code=1 → one key_strobe with key_value=1 at row_any+8, and entry_count=1.
- Key held for 1000 clocks with row_in toggling as during a scan → exactly one key_strobe.
- Press 1,2,3,4 then F, each separated by a release → result_valid pulse with result_match=1 and result_exact=4; entry_count returns to 0.
- Press 1,2,4,3 then F → result_match=0 and result_exact=2 (0 with CODE_ENTRY_PARTIAL_EN undefined).
- Press 5 digits, then F with count 3, then E → 5th digit ignored; F with a partial entry produces no result_valid; E zeroes entry and count.
- Assert rst during SETTLE → no key_strobe, entry 0, and the next press is accepted only after a 16-clock release.
